// File: rtl/reg_skid_slice_pkg.sv
// Shared state codes for the elastic slices and their monitors.
package reg_skid_slice_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } slice_state_e;

   localparam logic [1:0] OCC_MAX = 2'd2;

   // The state code doubles as the word count held by the slice.
   function automatic logic [1:0] occ_of(input slice_state_e st);
      return st;
   endfunction

endpackage

// File: rtl/reg_skid_slice.sv
// Valid/ready slice with a main register and one skid word; s_ready comes straight from a flop.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_EMPTY | nothing held, m_valid low
//  ST_BUSY  | one word in main, presented on m_data
//  ST_FULL  | main presented, skid holds the following word, s_ready low
module reg_skid_slice
   import reg_skid_slice_pkg::*;
#(
   parameter int                   REG_WIDTH   = 1,
   parameter logic [REG_WIDTH-1:0] REG_INITIAL = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [REG_WIDTH-1:0] s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [REG_WIDTH-1:0] m_data,
   output logic [1:0]           occ
);

   slice_state_e         state_q, state_d;
   logic [REG_WIDTH-1:0] main_q, main_d;
   logic [REG_WIDTH-1:0] skid_q, skid_d;
   logic                 s_ready_q, s_ready_d;
   logic                 in_fire, out_fire;

   assign m_valid  = (state_q != ST_EMPTY);
   assign m_data   = main_q;
   assign s_ready  = s_ready_q;
   assign occ      = occ_of(state_q);
   assign in_fire  = s_valid & s_ready_q;
   assign out_fire = m_valid & m_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = s_data;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               main_d = s_data;
            end else if (in_fire) begin
               skid_d  = s_data;
               state_d = ST_FULL;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_BUSY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush drops the held words but leaves the data registers untouched.
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
      s_ready_d = (state_d != ST_FULL) && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         main_q    <= REG_INITIAL;
         skid_q    <= REG_INITIAL;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         s_ready_q <= s_ready_d;
      end
   end

   a_occ_range: assert property (@(posedge clk) disable iff (rst) (occ <= OCC_MAX))
      else $error("occ out of range");

endmodule

// File: tb/tb_reg_skid_slice.sv
// Bench for reg_skid_slice: directed cases plus random throttling against a queue model.
module tb_reg_skid_slice;

   localparam int          W    = 32;
   localparam logic [31:0] INIT = 32'hC0DE_0001;

   logic          clk = 1'b0;
   logic          rst, flush, s_valid, m_ready;
   logic [W-1:0]  s_data;
   logic          s_ready, m_valid;
   logic [W-1:0]  m_data;
   logic [1:0]    occ;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] q[$];
   logic         exp_ready;
   int           n_acc, n_emit;

   reg_skid_slice #(.REG_WIDTH(W), .REG_INITIAL(INIT)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .occ(occ)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("m_valid", 64'(m_valid), 64'(q.size() > 0));
      check_val("occ", 64'(occ), 64'(q.size()));
      check_val("s_ready", 64'(s_ready), 64'(exp_ready));
      if (q.size() > 0) check_val("m_data", 64'(m_data), 64'(q[0]));
   endtask

   // One clock: drive inputs at negedge, advance the model at posedge, check just after.
   task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr,
                       input logic fl, input logic r);
      logic in_f, out_f;
      @(negedge clk);
      s_valid = sv; s_data = sd; m_ready = mr; flush = fl; rst = r;
      in_f  = sv && exp_ready;
      out_f = mr && (q.size() > 0);
      @(posedge clk);
      if (r || fl) begin
         q.delete();
         exp_ready = 1'b0;
      end else begin
         if (out_f) begin
            void'(q.pop_front());
            n_emit++;
         end
         if (in_f) begin
            q.push_back(sd);
            n_acc++;
         end
         exp_ready = (q.size() < 2);
      end
      #1;
      check_outputs();
   endtask

   initial begin
      int cycles;
      int offered;
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      exp_ready = 1'b0; n_acc = 0; n_emit = 0;

      // Reset
      for (int i = 0; i < 3; i++) step(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
      check_val("rst_m_data", 64'(m_data), 64'(INIT));
      check_val("rst_s_ready", 64'(s_ready), 64'd0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_val("first_ready", 64'(s_ready), 64'd1);

      // Streaming, no bubbles
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
         check_val("stream_data", 64'(m_data), 64'(i));
         check_val("stream_occ", 64'(occ), 64'd1);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_val("stream_drain", 64'(m_valid), 64'd0);

      // Stall then release
      step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
      check_val("stall_occ", 64'(occ), 64'd2);
      check_val("stall_ready", 64'(s_ready), 64'd0);
      step(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
      check_val("stall_hold", 64'(m_data), 64'hA1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_val("rel_a2", 64'(m_data), 64'hA2);
      check_val("rel_ready", 64'(s_ready), 64'd1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Simultaneous in/out in BUSY, then FULL with s_valid and m_ready
      step(1'b1, 32'hB1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'hB2, 1'b1, 1'b0, 1'b0);
      check_val("busy_swap", 64'(m_data), 64'hB2);
      check_val("busy_occ", 64'(occ), 64'd1);
      step(1'b1, 32'hB3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hB4, 1'b1, 1'b0, 1'b0);
      check_val("full_skid_next", 64'(m_data), 64'hB3);
      check_val("full_no_accept", 64'(occ), 64'd1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush while FULL
      step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hC3, 1'b1, 1'b1, 1'b0);
      check_val("flush_valid", 64'(m_valid), 64'd0);
      check_val("flush_ready", 64'(s_ready), 64'd0);
      step(1'b1, 32'hC4, 1'b1, 1'b0, 1'b0);
      check_val("flush_ready_back", 64'(s_ready), 64'd1);
      step(1'b1, 32'hC5, 1'b1, 1'b0, 1'b0);
      check_val("post_flush_word", 64'(m_data), 64'hC5);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Reset mid-transfer discards held words
      step(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hD2, 1'b0, 1'b0, 1'b1);
      check_val("midrst_m_data", 64'(m_data), 64'(INIT));
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Random throttling
      n_acc = 0; n_emit = 0; cycles = 0; offered = 0;
      while (n_emit < 10000 && cycles < 60000) begin
         logic sv, mr;
         sv = ($urandom_range(0, 99) < 70);
         mr = ($urandom_range(0, 99) < 65);
         step(sv, $urandom, mr, 1'b0, 1'b0);
         if (occ !== 2'(n_acc - n_emit)) check_val("rand_occ_balance", 64'(occ), 64'(n_acc - n_emit));
         cycles++;
         offered++;
      end
      check_val("rand_done", 64'(n_emit >= 10000), 64'd1);
      check_val("rand_balance", 64'(occ), 64'(n_acc - n_emit));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
